// File: rtl/mmsa_in_ctrl.sv
// Input controller for the matrix-multiply systolic array: deserialises matrix
// elements into the input/weight banks, then collects index pairs and launches the core.
module mmsa_in_ctrl #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              matrix,
   input  logic [1:0]        matrix_size,
   input  logic              in_valid2,
   input  logic              i_mat_idx,
   input  logic              w_mat_idx,
   input  logic              core_done,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [IDX_W-1:0]  wr_mat,
   output logic [5:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [1:0]        size_q,
   output logic              start,
   output logic [IDX_W-1:0]  i_idx,
   output logic [IDX_W-1:0]  w_idx,
   output logic              load_err,
   output logic              busy
);

   localparam int ELEM_W = 7 + IDX_W;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int ICNT_W = (IDX_W > 1) ? $clog2(IDX_W) : 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_WAIT_IDX = 3'd2;
   localparam logic [2:0] S_IDX      = 3'd3;
   localparam logic [2:0] S_START    = 3'd4;
   localparam logic [2:0] S_RUN      = 3'd5;

   logic [2:0]        state;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift_q;
   logic [ELEM_W-1:0] elem_cnt;
   logic [ICNT_W-1:0] idx_cnt;
   logic [IDX_W-1:0]  i_shift;
   logic [IDX_W-1:0]  w_shift;

   logic              start_load;
   logic              take_bit;
   logic              load_drop;
   logic [1:0]        norm_size;
   logic [1:0]        cur_size;
   logic [BIT_W-1:0]  cur_bits;
   logic [DATA_W-1:0] cur_shift;
   logic [DATA_W-1:0] next_shift;
   logic [ELEM_W-1:0] cur_elem;
   logic              elem_done;
   logic              elem_bank;
   logic [IDX_W-1:0]  elem_mat;
   logic [5:0]        elem_addr;
   logic [5:0]        addr_max;
   logic              last_elem;

   logic              start_idx;
   logic              take_idx;
   logic              idx_drop;
   logic [ICNT_W-1:0] cur_icnt;
   logic [IDX_W-1:0]  next_i;
   logic [IDX_W-1:0]  next_w;
   logic              idx_done;

   assign busy = (state == S_LOAD) || (state == S_IDX) ||
                 (state == S_START) || (state == S_RUN);

   // The first in_valid cycle already carries a bit, so it is treated as bit 0
   // of a freshly cleared element rather than waiting a cycle in LOAD.
   always_comb begin
      start_load = ((state == S_IDLE) || (state == S_WAIT_IDX)) && in_valid;
      take_bit   = start_load || ((state == S_LOAD) && in_valid);
      load_drop  = (state == S_LOAD) && !in_valid;
      norm_size  = (matrix_size == 2'd3) ? 2'd0 : matrix_size;
      cur_size   = start_load ? norm_size : size_q;
      cur_bits   = start_load ? '0 : bit_cnt;
      cur_shift  = start_load ? '0 : shift_q;
      cur_elem   = start_load ? '0 : elem_cnt;
      next_shift = cur_shift << 1;
      next_shift[0] = matrix;
      elem_done  = take_bit && (cur_bits == BIT_W'(DATA_W - 1));
   end

   // One flat element counter; the bank/matrix/address split moves with the matrix size.
   always_comb begin
      case (cur_size)
         2'd1: begin
            elem_addr = {2'b00, cur_elem[3:0]};
            elem_mat  = cur_elem[4 +: IDX_W];
            elem_bank = cur_elem[4 + IDX_W];
            addr_max  = 6'd15;
         end
         2'd2: begin
            elem_addr = cur_elem[5:0];
            elem_mat  = cur_elem[6 +: IDX_W];
            elem_bank = cur_elem[6 + IDX_W];
            addr_max  = 6'd63;
         end
         default: begin
            elem_addr = {4'b0000, cur_elem[1:0]};
            elem_mat  = cur_elem[2 +: IDX_W];
            elem_bank = cur_elem[2 + IDX_W];
            addr_max  = 6'd3;
         end
      endcase
      last_elem = elem_bank && (&elem_mat) && (elem_addr == addr_max);
   end

   // in_valid outranks in_valid2 in WAIT_IDX, so index capture only starts without it.
   always_comb begin
      start_idx = (state == S_WAIT_IDX) && !in_valid && in_valid2;
      take_idx  = start_idx || ((state == S_IDX) && in_valid2);
      idx_drop  = (state == S_IDX) && !in_valid2;
      cur_icnt  = start_idx ? '0 : idx_cnt;
      next_i    = (start_idx ? '0 : i_shift) << 1;
      next_w    = (start_idx ? '0 : w_shift) << 1;
      next_i[0] = i_mat_idx;
      next_w[0] = w_mat_idx;
      idx_done  = take_idx && (cur_icnt == ICNT_W'(IDX_W - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         bit_cnt  <= '0;
         shift_q  <= '0;
         elem_cnt <= '0;
         idx_cnt  <= '0;
         i_shift  <= '0;
         w_shift  <= '0;
         wr_en    <= 1'b0;
         wr_bank  <= 1'b0;
         wr_mat   <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         size_q   <= 2'd0;
         start    <= 1'b0;
         i_idx    <= '0;
         w_idx    <= '0;
         load_err <= 1'b0;
      end else begin
         wr_en    <= 1'b0;
         start    <= 1'b0;
         load_err <= 1'b0;
         if (start_load) begin
            size_q <= norm_size;
         end
         if (take_bit) begin
            if (elem_done) begin
               wr_en    <= 1'b1;
               wr_data  <= next_shift;
               wr_bank  <= elem_bank;
               wr_mat   <= elem_mat;
               wr_addr  <= elem_addr;
               bit_cnt  <= '0;
               shift_q  <= '0;
               elem_cnt <= cur_elem + 1'b1;
               state    <= last_elem ? S_WAIT_IDX : S_LOAD;
            end else begin
               bit_cnt  <= cur_bits + 1'b1;
               shift_q  <= next_shift;
               elem_cnt <= cur_elem;
               state    <= S_LOAD;
            end
         end else if (load_drop) begin
            load_err <= 1'b1;
            bit_cnt  <= '0;
            shift_q  <= '0;
            state    <= S_IDLE;
         end else if (take_idx) begin
            if (idx_done) begin
               start   <= 1'b1;
               i_idx   <= next_i;
               w_idx   <= next_w;
               idx_cnt <= '0;
               i_shift <= '0;
               w_shift <= '0;
               state   <= S_START;
            end else begin
               idx_cnt <= cur_icnt + 1'b1;
               i_shift <= next_i;
               w_shift <= next_w;
               state   <= S_IDX;
            end
         end else if (idx_drop) begin
            idx_cnt <= '0;
            i_shift <= '0;
            w_shift <= '0;
            state   <= S_WAIT_IDX;
         end else if (state == S_START) begin
            state <= S_RUN;
         end else if ((state == S_RUN) && core_done) begin
            state <= S_WAIT_IDX;
         end
      end
   end

endmodule

// File: tb/tb_mmsa_in_ctrl.sv
// Directed bench for mmsa_in_ctrl: full loads at each size, index rounds,
// aborted loads/indices and reset during LOAD and RUN.
module tb_mmsa_in_ctrl;

   localparam int DATA_W = 8;
   localparam int IDX_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              matrix = 1'b0;
   logic [1:0]        matrix_size = 2'd0;
   logic              in_valid2 = 1'b0;
   logic              i_mat_idx = 1'b0;
   logic              w_mat_idx = 1'b0;
   logic              core_done = 1'b0;
   logic              wr_en;
   logic              wr_bank;
   logic [IDX_W-1:0]  wr_mat;
   logic [5:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        size_q;
   logic              start;
   logic [IDX_W-1:0]  i_idx;
   logic [IDX_W-1:0]  w_idx;
   logic              load_err;
   logic              busy;

   int total = 0;
   int bad = 0;
   int wr_count, data_bad, addr_bad, start_count, err_count, overlap;
   int first_addr, first_data, first_mat, first_bank;
   int last_addr, last_mat, last_bank;
   int data_mode;
   int nn;

   mmsa_in_ctrl #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .matrix(matrix),
      .matrix_size(matrix_size), .in_valid2(in_valid2), .i_mat_idx(i_mat_idx),
      .w_mat_idx(w_mat_idx), .core_done(core_done), .wr_en(wr_en), .wr_bank(wr_bank),
      .wr_mat(wr_mat), .wr_addr(wr_addr), .wr_data(wr_data), .size_q(size_q),
      .start(start), .i_idx(i_idx), .w_idx(w_idx), .load_err(load_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] elem_value(input int k);
      if (data_mode == 0) return 8'hA5;
      return 8'(k % 256);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs, then samples 1 time unit after the rising edge.
   task automatic applyStimulus(input logic iv, input logic mbit, input logic [1:0] msize,
                                input logic iv2, input logic ibit, input logic wbit,
                                input logic cd);
      in_valid    = iv;
      matrix      = mbit;
      matrix_size = msize;
      in_valid2   = iv2;
      i_mat_idx   = ibit;
      w_mat_idx   = wbit;
      core_done   = cd;
      @(posedge clk);
      #1;
      if (wr_en === 1'b1) begin
         if (wr_count == 0) begin
            first_addr = int'(wr_addr);
            first_data = int'(wr_data);
            first_mat  = int'(wr_mat);
            first_bank = int'(wr_bank);
         end
         if (wr_data !== elem_value(wr_count)) data_bad++;
         if (wr_addr !== 6'(wr_count % nn) || wr_mat !== 4'((wr_count / nn) % 16) ||
             wr_bank !== 1'((wr_count / (nn * 16)) % 2)) addr_bad++;
         last_addr = int'(wr_addr);
         last_mat  = int'(wr_mat);
         last_bank = int'(wr_bank);
         wr_count++;
      end
      if (start === 1'b1) start_count++;
      if (load_err === 1'b1) err_count++;
      if (wr_en === 1'b1 && start === 1'b1) overlap++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_tracking();
      wr_count = 0; data_bad = 0; addr_bad = 0; start_count = 0; err_count = 0;
      first_addr = -1; first_data = -1; first_mat = -1; first_bank = -1;
      last_addr = -1; last_mat = -1; last_bank = -1;
   endtask

   // matrix_size is only meaningful on the first bit; later cycles carry a different code.
   task automatic send_load(input int n_elem, input int extra_bits, input logic [1:0] size,
                            input logic first_iv2);
      logic [7:0] v;
      for (int j = 0; j < n_elem * 8 + extra_bits; j++) begin
         v = elem_value(j / 8);
         applyStimulus(1'b1, v[7 - (j % 8)], (j == 0) ? size : (size ^ 2'b01),
                       (j == 0) ? first_iv2 : 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic send_index(input logic [3:0] ib, input logic [3:0] wb, input int nbits);
      for (int j = 0; j < nbits; j++)
         applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, ib[3 - j], wb[3 - j], 1'b0);
   endtask

   initial begin
      overlap = 0;
      data_mode = 0;
      nn = 4;
      clear_tracking();

      rst_n = 1'b0;
      idle(2);
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_start", 32'(start), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_size_q", 32'(size_q), 32'd0);
      checkOutput("rst_i_idx", 32'(i_idx), 32'd0);
      checkOutput("rst_w_idx", 32'(w_idx), 32'd0);
      checkOutput("rst_load_err", 32'(load_err), 32'd0);
      rst_n = 1'b1;
      idle(1);

      // 2x2 load of constant A5
      send_load(128, 0, 2'd0, 1'b0);
      checkOutput("a5_count", 32'(wr_count), 32'd128);
      checkOutput("a5_first_bank", 32'(first_bank), 32'd0);
      checkOutput("a5_first_mat", 32'(first_mat), 32'd0);
      checkOutput("a5_first_addr", 32'(first_addr), 32'd0);
      checkOutput("a5_first_data", 32'(first_data), 32'hA5);
      checkOutput("a5_last_bank", 32'(last_bank), 32'd1);
      checkOutput("a5_last_mat", 32'(last_mat), 32'd15);
      checkOutput("a5_last_addr", 32'(last_addr), 32'd3);
      checkOutput("a5_data", 32'(data_bad), 32'd0);
      checkOutput("a5_addr_seq", 32'(addr_bad), 32'd0);
      checkOutput("a5_busy", 32'(busy), 32'd0);
      checkOutput("a5_size_q", 32'(size_q), 32'd0);
      idle(2);
      checkOutput("a5_no_extra", 32'(wr_count), 32'd128);

      // index round i=0101 w=1010, core_done 7 cycles after start
      send_index(4'b0101, 4'b1010, 3);
      checkOutput("idx_early", 32'(start_count), 32'd0);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("idx_start", 32'(start), 32'd1);
      checkOutput("idx_i", 32'(i_idx), 32'd5);
      checkOutput("idx_w", 32'(w_idx), 32'd10);
      idle(7);
      checkOutput("idx_start_once", 32'(start_count), 32'd1);
      checkOutput("run_busy", 32'(busy), 32'd1);
      checkOutput("idx_held", 32'(i_idx), 32'd5);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("run_done", 32'(busy), 32'd0);

      // aborted index, then a full one; core_done in START and in_valid in RUN are ignored
      send_index(4'b1000, 4'b0100, 2);
      idle(1);
      checkOutput("idx_drop_nostart", 32'(start_count), 32'd1);
      checkOutput("idx_drop_wait", 32'(busy), 32'd0);
      send_index(4'b0011, 4'b1100, 4);
      checkOutput("idx2_start", 32'(start), 32'd1);
      checkOutput("idx2_i", 32'(i_idx), 32'd3);
      checkOutput("idx2_w", 32'(w_idx), 32'd12);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("cd_in_start_ignored", 32'(busy), 32'd1);
      applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("iv_in_run_busy", 32'(busy), 32'd1);
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("run2_done", 32'(busy), 32'd0);
      checkOutput("run2_no_err", 32'(err_count), 32'd0);
      checkOutput("run2_no_write", 32'(wr_count), 32'd128);

      // 8x8 load entered with both valids high, element k = k mod 256
      clear_tracking();
      data_mode = 1;
      nn = 64;
      send_load(2048, 0, 2'd2, 1'b1);
      checkOutput("s2_count", 32'(wr_count), 32'd2048);
      checkOutput("s2_first_data", 32'(first_data), 32'd0);
      checkOutput("s2_data", 32'(data_bad), 32'd0);
      checkOutput("s2_addr_seq", 32'(addr_bad), 32'd0);
      checkOutput("s2_last_bank", 32'(last_bank), 32'd1);
      checkOutput("s2_last_mat", 32'(last_mat), 32'd15);
      checkOutput("s2_last_addr", 32'(last_addr), 32'd63);
      checkOutput("s2_size_q", 32'(size_q), 32'd2);
      checkOutput("s2_busy", 32'(busy), 32'd0);
      checkOutput("both_valid_no_start", 32'(start_count), 32'd0);

      // size code 3 behaves as 2x2; drop after 3 bits of element 5
      clear_tracking();
      nn = 4;
      send_load(5, 3, 2'd3, 1'b0);
      checkOutput("size3_norm", 32'(size_q), 32'd0);
      checkOutput("err_busy_before", 32'(busy), 32'd1);
      checkOutput("err_none_yet", 32'(err_count), 32'd0);
      idle(1);
      checkOutput("err_pulse", 32'(load_err), 32'd1);
      checkOutput("err_idle", 32'(busy), 32'd0);
      idle(1);
      checkOutput("err_one_cycle", 32'(load_err), 32'd0);
      checkOutput("err_writes", 32'(wr_count), 32'd5);
      checkOutput("err_last_mat", 32'(last_mat), 32'd1);
      checkOutput("err_last_addr", 32'(last_addr), 32'd0);
      checkOutput("err_data", 32'(data_bad), 32'd0);

      // reset mid-LOAD, then a fresh 4x4 load
      clear_tracking();
      nn = 16;
      send_load(0, 4, 2'd1, 1'b0);
      rst_n = 1'b0;
      idle(1);
      checkOutput("rst_load_no_err", 32'(load_err), 32'd0);
      checkOutput("rst_load_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      send_load(512, 0, 2'd1, 1'b0);
      checkOutput("s1_count", 32'(wr_count), 32'd512);
      checkOutput("s1_first_addr", 32'(first_addr), 32'd0);
      checkOutput("s1_first_data", 32'(first_data), 32'd0);
      checkOutput("s1_data", 32'(data_bad), 32'd0);
      checkOutput("s1_addr_seq", 32'(addr_bad), 32'd0);
      checkOutput("s1_last_addr", 32'(last_addr), 32'd15);
      checkOutput("s1_last_mat", 32'(last_mat), 32'd15);
      checkOutput("s1_last_bank", 32'(last_bank), 32'd1);
      checkOutput("s1_size_q", 32'(size_q), 32'd1);
      checkOutput("s1_no_err", 32'(err_count), 32'd0);

      // reset during RUN, then a stray core_done
      send_index(4'b0110, 4'b1001, 4);
      checkOutput("s1_idx_start", 32'(start), 32'd1);
      checkOutput("s1_idx_i", 32'(i_idx), 32'd6);
      idle(2);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rrun_busy", 32'(busy), 32'd0);
      checkOutput("rrun_start", 32'(start), 32'd0);
      checkOutput("rrun_i_idx", 32'(i_idx), 32'd0);
      checkOutput("rrun_w_idx", 32'(w_idx), 32'd0);
      checkOutput("rrun_size_q", 32'(size_q), 32'd0);
      checkOutput("rrun_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rrun_load_err", 32'(load_err), 32'd0);
      idle(2);
      checkOutput("rrun_stay_idle", 32'(busy), 32'd0);
      checkOutput("rrun_start_count", 32'(start_count), 32'd1);

      checkOutput("no_wr_start_overlap", 32'(overlap), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmsa_in_ctrl.md
MMSA_IN_CTRL -- requirements
Module: mmsa_in_ctrl

Interface
REQ-001: Parameter DATA_W, default 8, is the element width in bits, received serially.
REQ-002: Parameter IDX_W, default 4, is the matrix index width; 2**IDX_W matrices per bank.
REQ-003: Port clk, input, 1, is the single clock; all logic is on the rising edge.
REQ-004: Port rst_n, input, 1, is the reset: synchronous, active-low.
REQ-005: Port in_valid, input, 1, qualifies matrix load bits.
REQ-006: Port matrix, input, 1, is the serial element bit, MSB first.
REQ-007: Port matrix_size, input, 2, is sampled on the first in_valid cycle only: 0=2x2, 1=4x4, 2=8x8, 3=treated as 2x2.
REQ-008: Port in_valid2, input, 1, qualifies index bits.
REQ-009: Port i_mat_idx, input, 1, is the serial input-matrix index bit, MSB first.
REQ-010: Port w_mat_idx, input, 1, is the serial weight-matrix index bit, MSB first.
REQ-011: Port core_done, input, 1, is a one-cycle pulse from the datapath when a multiply completes.
REQ-012: Port wr_en, output, 1, is the element write strobe.
REQ-013: Port wr_bank, output, 1, selects the bank: 0=input, 1=weight.
REQ-014: Port wr_mat, output, IDX_W, is the matrix number within the bank.
REQ-015: Port wr_addr, output, 6, is the row-major element index.
REQ-016: Port wr_data, output, DATA_W, is the assembled element.
REQ-017: Port size_q, output, 2, is the latched, normalised size code (0/1/2).
REQ-018: Port start, output, 1, is a one-cycle datapath launch pulse.
REQ-019: Port i_idx / w_idx, output, IDX_W each, carry indices valid while start=1 and held until the next start.
REQ-020: Port load_err, output, 1, is a one-cycle pulse when in_valid drops mid-load.
REQ-021: Port busy, output, 1, is high in LOAD, IDX, START and RUN.

Function
REQ-022: States are IDLE, LOAD, WAIT_IDX, IDX, START and RUN.
REQ-023: IDLE: in_valid=1 -> LOAD. That cycle's matrix bit is bit 0 of the stream, and matrix_size is latched.
REQ-024: LOAD accumulates bits MSB first. After DATA_W bits, the next cycle asserts wr_en=1 for exactly one cycle with wr_data = the assembled element.
REQ-025: Per matrix, N*N elements are written (N=2/4/8), with wr_addr 0..N*N-1.
REQ-026: Matrix order is input bank mats 0..15, then weight bank mats 0..15. wr_bank, wr_mat and wr_addr come from a single counter.
REQ-027: After the write of weight mat 15, last element, the FSM goes to WAIT_IDX. in_valid is required low from that cycle.
REQ-028: If in_valid=0 in LOAD before the final bit: pulse load_err one cycle later, discard the partial element, go to IDLE. Elements already written stand.
REQ-029: WAIT_IDX: in_valid2=1 -> IDX, and that cycle supplies index bit 3.
REQ-030: WAIT_IDX: in_valid=1 -> LOAD as a new pattern, with the size relatched and counters cleared.
REQ-031: When in_valid and in_valid2 are both high in IDLE or WAIT_IDX, in_valid has priority.
REQ-032: IDX shifts exactly IDX_W bits. On the cycle after the last bit the FSM enters START and start=1 with i_idx/w_idx final.
REQ-033: In IDX, an in_valid2 drop before IDX_W bits discards the partial index and returns to WAIT_IDX without a start.
REQ-034: START lasts one cycle, then RUN.
REQ-035: RUN waits for core_done=1, then returns to WAIT_IDX. Unlimited index rounds are allowed per load.
REQ-036: core_done outside RUN is ignored; in_valid and in_valid2 in START or RUN are ignored.
REQ-037: wr_en and start are never high in the same cycle.

Reset
REQ-038: When rst_n=0 at a clock edge: state=IDLE, all counters and shift registers cleared, all outputs 0 (size_q=0, i_idx=w_idx=0).
REQ-039: Reset mid-LOAD or mid-RUN aborts without a load_err or start pulse. The next in_valid starts a fresh pattern.

Verification
REQ-040: Size 0, 1024 bits, all elements 8'hA5 -> 128 wr_en pulses. The first is bank0/mat0/addr0 with data A5; the last is bank1/mat15/addr3. Then WAIT_IDX and busy=0.
REQ-041: Size 2, element k = k mod 256 -> 2048 writes. Addr wraps 63->0 at each matrix boundary; wr_data matches k.
REQ-042: After load, in_valid2 for 4 cycles with i bits 0101 and w bits 1010 -> start exactly once, the cycle after the 4th bit, with i_idx=5 and w_idx=10. core_done 7 cycles later -> WAIT_IDX.
REQ-043: in_valid drop after 3 bits of element 5 -> load_err one cycle later, IDLE, 5 writes only. Separately, in_valid2 drop after 2 bits -> no start, WAIT_IDX.
REQ-044: rst_n=0 in RUN, then core_done pulse -> outputs 0, no transition.
REQ-045: in_valid and in_valid2 both high in WAIT_IDX -> LOAD.
REQ-046: matrix_size=3 -> size_q=0.
